integral_rect_reader: RTL and testbench
=======================================

INTEGRAL_RECT_READER -- requirements
Module: integral_rect_reader

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 10, meaning the integral-buffer address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 8, meaning the integral-buffer word width.
REQ-003 The module SHALL have port clk_os, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset_os, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port req_valid, input, 1 bit: a rectangle request is present.
REQ-006 The module SHALL have port req_ready, output, 1 bit: the module accepts a request this cycle.
REQ-007 The module SHALL have ports index_a_1, index_b_2, index_c_3 and index_d_4, input, ADDR_WIDTH each: the addresses of corner A (top-left), B (top-right), C (bottom-left) and D (bottom-right).
REQ-008 The module SHALL have port mem_ren, output, 1 bit: integral-buffer read strobe.
REQ-009 The module SHALL have port mem_addr, output, ADDR_WIDTH: integral-buffer read address.
REQ-010 The module SHALL have port mem_rdata, input, DATA_WIDTH: read data, valid exactly one cycle after mem_ren.
REQ-011 The module SHALL have port rect_valid, output, 1 bit: rect_sum holds a valid result.
REQ-012 The module SHALL have port rect_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The module SHALL have port rect_sum, output, DATA_WIDTH+2, signed two's complement: the rectangle sum D-B-C+A.
REQ-014 The module SHALL have port rect_count, output, 16 bits: the number of results delivered, wrapping modulo 2^16.
REQ-015 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, RD_A, RD_B, RD_C, RD_D, CAP_D and OUT.
REQ-017 req_ready SHALL be 1 only in IDLE.
REQ-018 Acceptance SHALL be req_valid&&req_ready in cycle T; all four indices SHALL be latched at T, and their later changes SHALL be ignored.
REQ-019 In cycles T+1..T+4 (states RD_A..RD_D), mem_ren SHALL be 1 with mem_addr = latched A, B, C, D respectively.
REQ-020 mem_ren SHALL be 0 in all other states, and mem_addr SHALL hold its last value when mem_ren is 0.
REQ-021 The accumulator SHALL be cleared at acceptance.
REQ-022 At the end of cycles T+2..T+5, the accumulator SHALL update as: +A, -B, -C, +D (zero-extended mem_rdata).
REQ-023 rect_valid SHALL rise in cycle T+6 (state OUT), giving a fixed latency of 6 cycles from acceptance to result.
REQ-024 rect_valid and rect_sum SHALL stay stable while rect_ready is 0.
REQ-025 On rect_valid&&rect_ready, the FSM SHALL return to IDLE next cycle, rect_valid SHALL drop, and rect_count SHALL increment by 1.
REQ-026 The earliest next acceptance SHALL be the cycle after the output handshake; there is no request overlap.
REQ-027 req_valid SHALL be ignored while busy, with no queuing.
REQ-028 rect_ready SHALL be ignored when rect_valid is 0.
REQ-029 Arithmetic SHALL be full-width with no overflow: the result range is ±2*(2^DATA_WIDTH-1), which fits in DATA_WIDTH+2 signed bits.
REQ-030 rect_sum SHALL hold the last result after the handshake until the next result is loaded.
REQ-031 rect_count SHALL wrap from 0xFFFF to 0x0000 on the next delivered result.

Reset
REQ-032 When reset_os=0 at a rising edge, the next state SHALL be IDLE in every state, including mid-read.
REQ-033 Reset SHALL set req_ready=1, busy=0, mem_ren=0, mem_addr=0, rect_valid=0, rect_sum=0, rect_count=0 and accumulator=0.
REQ-034 An in-flight request SHALL be discarded by reset and SHALL produce no result.
REQ-035 A mem_rdata value returning in the cycle after reset SHALL be ignored.
REQ-036 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 The bench SHALL cover basic operation: A=10, B=20, C=30, D=100, read data matching, rect_ready=1 -> mem_ren at T+1..T+4 with addresses in order A, B, C, D; rect_valid at T+6; rect_sum=60; rect_count=1.
REQ-038 The bench SHALL cover the negative extreme at DATA_WIDTH=8: data A=0, B=255, C=255, D=0 -> rect_sum=-510 (10'h202).
REQ-039 The bench SHALL cover backpressure: rect_ready=0 for 5 cycles after rect_valid -> rect_valid and rect_sum stable; after rect_ready=1, req_ready=1 in the following cycle.
REQ-040 The bench SHALL cover busy rejection: req_valid held high with changing indices during RD_B -> no second acceptance, and the addresses remain the original latched values.
REQ-041 The bench SHALL cover reset mid-operation: reset_os=0 during RD_C -> the next cycle shows IDLE, mem_ren=0, rect_valid=0 and rect_count unchanged at 0; a fresh request then completes correctly.
REQ-042 The bench SHALL cover counter wrap: rect_count forced to 0xFFFF by running 65535 requests, then one more request -> rect_count=0x0000.

Source files
------------

// File: rtl/integral_rect_reader_if.sv
// -----------------------------------------------------------------------------
// integral_rect_reader_if
// Bundles the request, integral-buffer read and result signals of
// integral_rect_reader.
//   req_valid/req_ready       : rectangle request handshake
//   index_a_1..index_d_4      : corner addresses A (TL), B (TR), C (BL), D (BR)
//   mem_ren/mem_addr/mem_rdata: integral-buffer read port (1-cycle read latency)
//   rect_valid/rect_ready     : result handshake
//   rect_sum                  : signed D-B-C+A, DATA_WIDTH+2 bits
//   rect_count                : delivered-result counter (wraps mod 2^16)
//   busy                      : reader is not idle
// Modports: slave = the reader, master = the requester/memory/consumer side.
// -----------------------------------------------------------------------------
interface integral_rect_reader_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic [ADDR_WIDTH-1:0]   index_a_1;
    logic [ADDR_WIDTH-1:0]   index_b_2;
    logic [ADDR_WIDTH-1:0]   index_c_3;
    logic [ADDR_WIDTH-1:0]   index_d_4;
    logic                    mem_ren;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_rdata;
    logic                    rect_valid;
    logic                    rect_ready;
    logic [DATA_WIDTH+1:0]   rect_sum;
    logic [15:0]             rect_count;
    logic                    busy;

    modport slave (
        input  req_valid, index_a_1, index_b_2, index_c_3, index_d_4,
               mem_rdata, rect_ready,
        output req_ready, mem_ren, mem_addr, rect_valid, rect_sum,
               rect_count, busy
    );

    modport master (
        output req_valid, index_a_1, index_b_2, index_c_3, index_d_4,
               mem_rdata, rect_ready,
        input  req_ready, mem_ren, mem_addr, rect_valid, rect_sum,
               rect_count, busy
    );
endinterface

// File: rtl/integral_rect_reader.sv
// -----------------------------------------------------------------------------
// integral_rect_reader
// Reads the four corners of a rectangle from an integral image buffer and
// returns the rectangle sum D - B - C + A with a fixed 6-cycle latency from
// request acceptance to result.
// Ports:
//   clk_os   : single clock, rising edge
//   reset_os : synchronous, active-low reset
//   bus      : integral_rect_reader_if.slave (request, memory read, result)
// -----------------------------------------------------------------------------
module integral_rect_reader #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_os,
    input  logic                  reset_os,
    integral_rect_reader_if.slave bus
);
    localparam int SUM_WIDTH = DATA_WIDTH + 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_B,
        RD_C,
        RD_D,
        CAP_D,
        OUT
    } state_t;

    state_t                       state_q;
    state_t                       state_d;
    logic [ADDR_WIDTH-1:0]        idx_b_q;
    logic [ADDR_WIDTH-1:0]        idx_c_q;
    logic [ADDR_WIDTH-1:0]        idx_d_q;
    logic [ADDR_WIDTH-1:0]        addr_q;
    logic signed [SUM_WIDTH-1:0]  acc_q;
    logic signed [SUM_WIDTH-1:0]  sum_q;
    logic signed [SUM_WIDTH-1:0]  rdata_ext;
    logic [15:0]                  count_q;
    logic                         accept;
    logic                         deliver;

    assign accept    = (state_q == IDLE) && bus.req_valid;
    assign deliver   = (state_q == OUT) && bus.rect_ready;
    assign rdata_ext = $signed({2'b00, bus.mem_rdata});

    // State register
    always_ff @(posedge clk_os) begin
        if (!reset_os) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.req_valid) state_d = RD_A;
            RD_A:    state_d = RD_B;
            RD_B:    state_d = RD_C;
            RD_C:    state_d = RD_D;
            RD_D:    state_d = CAP_D;
            CAP_D:   state_d = OUT;
            OUT:     if (bus.rect_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath. Corner A goes straight into the address register at
    // acceptance, so only B, C and D need holding registers. Read data lags
    // the address by one state, hence +A lands in RD_B and +D in CAP_D.
    always_ff @(posedge clk_os) begin
        if (!reset_os) begin
            idx_b_q <= '0;
            idx_c_q <= '0;
            idx_d_q <= '0;
            addr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.index_a_1;
                idx_b_q <= bus.index_b_2;
                idx_c_q <= bus.index_c_3;
                idx_d_q <= bus.index_d_4;
                acc_q   <= '0;
            end
            case (state_q)
                RD_A: addr_q <= idx_b_q;
                RD_B: begin
                    addr_q <= idx_c_q;
                    acc_q  <= acc_q + rdata_ext;
                end
                RD_C: begin
                    addr_q <= idx_d_q;
                    acc_q  <= acc_q - rdata_ext;
                end
                RD_D: acc_q <= acc_q - rdata_ext;
                CAP_D: begin
                    acc_q <= acc_q + rdata_ext;
                    sum_q <= acc_q + rdata_ext;
                end
                default: ;
            endcase
            if (deliver) begin
                count_q <= count_q + 16'd1;
            end
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.mem_ren    = (state_q == RD_A) || (state_q == RD_B) ||
                            (state_q == RD_C) || (state_q == RD_D);
    assign bus.mem_addr   = addr_q;
    assign bus.rect_valid = (state_q == OUT);
    assign bus.rect_sum   = sum_q;
    assign bus.rect_count = count_q;
endmodule

// File: tb/tb_integral_rect_reader.sv
// -----------------------------------------------------------------------------
// tb_integral_rect_reader
// Self-checking bench for integral_rect_reader (ADDR_WIDTH=10, DATA_WIDTH=8).
// A behavioural integral buffer answers reads one cycle after mem_ren and
// returns random garbage otherwise. Expected sums are D-B-C+A in plain
// integer arithmetic over the buffer contents.
// -----------------------------------------------------------------------------
module tb_integral_rect_reader;
    localparam int AW = 10;
    localparam int DW = 8;

    logic clk_os;
    logic reset_os;

    integral_rect_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    integral_rect_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_os   (clk_os),
        .reset_os (reset_os),
        .bus      (bus)
    );

    initial clk_os = 1'b0;
    always #5 clk_os = ~clk_os;

    logic [DW-1:0] mem [1024];

    always @(posedge clk_os) begin
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];
        else             bus.mem_rdata <= DW'($urandom);
    end

    int          checks;
    int          errors;
    logic [15:0] exp_count;

    typedef struct {
        logic [AW-1:0] a, b, c, d;
        logic [DW-1:0] da, db, dc, dd;
        int            stall;
        bit            hold;
        int            exp_sum;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Caller is at a negedge in an IDLE cycle (cycle T). Returns at the
    // negedge of the first IDLE cycle after the result handshake.
    task automatic run_req(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] c, input logic [AW-1:0] d,
                           input int stall, input bit hold, input int exp_sum);
        logic [AW-1:0] exp_addr [4];
        logic [15:0]   cnt_before;
        exp_addr[0] = a; exp_addr[1] = b; exp_addr[2] = c; exp_addr[3] = d;
        cnt_before = exp_count;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("mem_ren_idle", 32'(bus.mem_ren), 32'd0);
        bus.req_valid  = 1'b1;
        bus.index_a_1  = a;
        bus.index_b_2  = b;
        bus.index_c_3  = c;
        bus.index_d_4  = d;
        bus.rect_ready = 1'($urandom_range(0, 1));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_os);
            if (!hold) bus.req_valid = 1'b0;
            bus.index_a_1  = AW'($urandom);
            bus.index_b_2  = AW'($urandom);
            bus.index_c_3  = AW'($urandom);
            bus.index_d_4  = AW'($urandom);
            bus.rect_ready = 1'($urandom_range(0, 1));
            chk("mem_ren_read", 32'(bus.mem_ren), 32'd1);
            chk("mem_addr_read", 32'(bus.mem_addr), 32'(exp_addr[k]));
            chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
            chk("busy_read", 32'(bus.busy), 32'd1);
            chk("rect_valid_early", 32'(bus.rect_valid), 32'd0);
        end
        @(negedge clk_os);  // T+5
        bus.req_valid = 1'b0;
        chk("mem_ren_cap", 32'(bus.mem_ren), 32'd0);
        chk("mem_addr_hold", 32'(bus.mem_addr), 32'(d));
        chk("rect_valid_cap", 32'(bus.rect_valid), 32'd0);
        bus.rect_ready = (stall == 0);
        @(negedge clk_os);  // T+6
        chk("rect_valid_t6", 32'(bus.rect_valid), 32'd1);
        chk("rect_sum", 32'($signed(bus.rect_sum)), 32'(exp_sum));
        chk("mem_ren_out", 32'(bus.mem_ren), 32'd0);
        for (int s = 0; s < stall; s++) begin
            @(negedge clk_os);
            chk("rect_valid_stall", 32'(bus.rect_valid), 32'd1);
            chk("rect_sum_stall", 32'($signed(bus.rect_sum)), 32'(exp_sum));
            chk("rect_count_stall", 32'(bus.rect_count), 32'(cnt_before));
            if (s == stall - 1) bus.rect_ready = 1'b1;
        end
        @(negedge clk_os);
        exp_count = cnt_before + 16'd1;
        chk("rect_valid_drop", 32'(bus.rect_valid), 32'd0);
        chk("req_ready_after", 32'(bus.req_ready), 32'd1);
        chk("rect_count", 32'(bus.rect_count), 32'(exp_count));
        chk("rect_sum_hold", 32'($signed(bus.rect_sum)), 32'(exp_sum));
        bus.rect_ready = 1'($urandom_range(0, 1));
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        exp_count     = '0;
        reset_os      = 1'b0;
        bus.req_valid = 1'b0;
        bus.rect_ready = 1'b0;
        bus.index_a_1 = '0;
        bus.index_b_2 = '0;
        bus.index_c_3 = '0;
        bus.index_d_4 = '0;
        for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);

        // Directed vectors: {A,B,C,D addresses, corner data, stall, hold, sum}
        vecs[0] = '{10'd10,   10'd20, 10'd30,  10'd100, 8'd10,  8'd20,  8'd30,  8'd100, 0, 1'b0,   60};
        vecs[1] = '{10'd1,    10'd2,  10'd3,   10'd4,   8'd0,   8'd255, 8'd255, 8'd0,   0, 1'b0, -510};
        vecs[2] = '{10'd5,    10'd6,  10'd7,   10'd8,   8'd255, 8'd0,   8'd0,   8'd255, 0, 1'b0,  510};
        vecs[3] = '{10'd1023, 10'd0,  10'd512, 10'd511, 8'd7,   8'd9,   8'd200, 8'd3,   5, 1'b0, -199};
        vecs[4] = '{10'd40,   10'd41, 10'd42,  10'd43,  8'd100, 8'd50,  8'd25,  8'd75,  2, 1'b0,  100};
        vecs[5] = '{10'd200,  10'd300, 10'd400, 10'd500, 8'd1,  8'd2,   8'd3,   8'd4,   1, 1'b1,    0};

        // Reset state
        repeat (3) @(negedge clk_os);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_rect_valid", 32'(bus.rect_valid), 32'd0);
        chk("rst_rect_sum", 32'(bus.rect_sum), 32'd0);
        chk("rst_rect_count", 32'(bus.rect_count), 32'd0);
        reset_os = 1'b1;
        @(negedge clk_os);
        chk("rst_release_ready", 32'(bus.req_ready), 32'd1);

        // Reset during RD_C discards the request
        bus.req_valid = 1'b1;
        bus.index_a_1 = 10'd100;
        bus.index_b_2 = 10'd101;
        bus.index_c_3 = 10'd102;
        bus.index_d_4 = 10'd103;
        @(negedge clk_os);  // RD_A
        bus.req_valid = 1'b0;
        @(negedge clk_os);  // RD_B
        @(negedge clk_os);  // RD_C
        chk("midrst_addr_c", 32'(bus.mem_addr), 32'd102);
        reset_os = 1'b0;
        @(negedge clk_os);
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midrst_mem_ren", 32'(bus.mem_ren), 32'd0);
        chk("midrst_rect_valid", 32'(bus.rect_valid), 32'd0);
        chk("midrst_rect_count", 32'(bus.rect_count), 32'd0);
        reset_os = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_os);
            chk("midrst_no_result", 32'(bus.rect_valid), 32'd0);
            chk("midrst_idle", 32'(bus.req_ready), 32'd1);
        end
        mem[100] = 8'd50; mem[101] = 8'd20; mem[102] = 8'd5; mem[103] = 8'd90;
        run_req(10'd100, 10'd101, 10'd102, 10'd103, 0, 1'b0, 90 - 20 - 5 + 50);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            mem[vecs[i].a] = vecs[i].da;
            mem[vecs[i].b] = vecs[i].db;
            mem[vecs[i].c] = vecs[i].dc;
            mem[vecs[i].d] = vecs[i].dd;
            run_req(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                    vecs[i].stall, vecs[i].hold, vecs[i].exp_sum);
        end
        chk("no_extra_accept", 32'(bus.busy), 32'd0);

        // Randomized requests against the arithmetic model
        for (int n = 0; n < 40; n++) begin
            logic [AW-1:0] ra, rb, rc, rd;
            int            es;
            ra = AW'($urandom); rb = AW'($urandom);
            rc = AW'($urandom); rd = AW'($urandom);
            mem[ra] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
            mem[rb] = ($urandom_range(0, 3) == 0) ? 8'd255 : DW'($urandom);
            mem[rc] = ($urandom_range(0, 3) == 0) ? 8'd0   : DW'($urandom);
            mem[rd] = ($urandom_range(0, 3) == 0) ? 8'd0   : DW'($urandom);
            es = int'(mem[rd]) - int'(mem[rb]) - int'(mem[rc]) + int'(mem[ra]);
            run_req(ra, rb, rc, rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)), es);
        end

        // Counter wrap: preload the count instead of running 65535 requests
        force dut.count_q = 16'hFFFF;
        @(negedge clk_os);
        release dut.count_q;
        exp_count = 16'hFFFF;
        mem[10'd11] = 8'd3; mem[10'd12] = 8'd4; mem[10'd13] = 8'd5; mem[10'd14] = 8'd6;
        run_req(10'd11, 10'd12, 10'd13, 10'd14, 0, 1'b0, 6 - 4 - 5 + 3);
        chk("count_wrap", 32'(bus.rect_count), 32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
